dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// Shares the single synchronous data-memory port between two requesters:
// port 0 (core load/store path: ALUResult/WriteData/MemWrite/Byte_Enable) and
// port 1 (debug/DMA loader). Round-robin arbitration with a burst limit,
// a registered issue stage, and read-response routing back to the issuing port.
// Sits between the core/loader and the data RAM in the SoC top.
// PARAMETERS
// ADDR_W     32  address width, passed through unchanged
// DATA_W     32  data width; byte-enable width is DATA_W/8
// MAX_BURST  4   consecutive grants the current owner may take while the other port waits (>=1)
// MEM_LAT    1   cycles from mem_req (read) to mem_rdata valid (>=1)
// PORTS
// clk         in   1         clock, all logic on rising edge
// rst         in   1         synchronous reset, active-high
// mX_valid    in   1         port X (X=0,1) request valid
// mX_ready    out  1         port X request accepted this cycle
// mX_we       in   1         1=write, 0=read
// mX_addr     in   ADDR_W    request address
// mX_wdata    in   DATA_W    write data
// mX_be       in   DATA_W/8  write byte enables
// mX_rvalid   out  1         read data valid for port X
// mX_rdata    out  DATA_W    read data (mem_rdata passthrough)
// mem_req     out  1         memory access this cycle
// mem_we      out  1         memory write strobe
// mem_addr    out  ADDR_W    memory address
// mem_wdata   out  DATA_W    memory write data
// mem_be      out  DATA_W/8  memory byte enables
// mem_rdata   in   DATA_W    memory read data, MEM_LAT cycles after read mem_req
// BEHAVIOUR
// - Reset (sync, rst=1): mem_req/mem_we=0, mem_addr/wdata/be=0, m0/m1_rvalid=0,
//   owner=0, burst_cnt=0, response pipe cleared. mX_ready=0 while rst=1.
// - Accept: mX_ready = mX_valid & grant_X, combinational; at most one ready per
//   cycle. Request transfers when valid&ready. Memory never backpressures:
//   throughput one access per cycle.
// - Arbitration: only one valid -> grant it. Both valid -> grant owner if
//   burst_cnt < MAX_BURST, else grant the other port. Neither -> no grant,
//   owner/burst_cnt hold.
// - Owner update on grant: same port as owner -> burst_cnt++ (saturate at
//   MAX_BURST); different port -> owner=granted, burst_cnt=1. Out of reset
//   port 0 wins a tie.
// - Issue stage (1 cycle): grant in cycle T -> mem_req=1 and mem_* fields
//   registered from the granted port in T+1. No grant -> mem_req=0, mem_we=0,
//   other mem_* hold.
// - Reads: mem_be forced all-ones, mem_wdata=0. Writes: mem_be=mX_be,
//   mem_wdata=mX_wdata. Address never modified.
// - Response: shift pipe of {valid, id} of depth MEM_LAT loaded at issue for
//   reads only. Read granted at T -> mX_rvalid=1 for exactly one cycle at
//   T+1+MEM_LAT, only on the issuing port. mX_rdata = mem_rdata on both ports
//   at all times; valid only with rvalid. Writes produce no response.
// - In-order: responses return in issue order; back-to-back reads from
//   alternating ports give alternating rvalid on consecutive cycles.
// - Reset mid-operation: issued-but-unreturned reads are dropped; no rvalid
//   asserts after rst deasserts until a new read is issued.
// - A valid request held without ready must keep its fields stable.
//   Arbiter behaviour is undefined otherwise (not checked).
// TESTING
// 1) Reset, only m0 read addr=0x100, MEM_LAT=1 -> m0_ready at T, mem_req/addr=0x100
//    at T+1, m0_rvalid with RAM word at T+2; m1_rvalid stays 0.
// 2) m1 write addr=0x200 wdata=0xDEADBEEF be=4'b0011 -> mem_we=1, mem_be=0011
//    at T+1; no rvalid; a later read of 0x200 returns the low halfword updated.
// 3) Both valid continuously from reset, MAX_BURST=4 -> grant sequence
//    0,0,0,0,1,1,1,1,0...; never 5 consecutive grants to one port.
// 4) Alternating reads m0@0x10, m1@0x14 each cycle -> rvalid alternates
//    m0,m1 on consecutive cycles, each with its own address's data.
// 5) m0 read issued, rst=1 for 1 cycle before response -> m0_rvalid never
//    asserts; all outputs 0 during reset; m0 wins the first tie after reset.
// 6) MEM_LAT=3 build, 3 back-to-back m0 reads -> three rvalid pulses at T+4..T+6, in order.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port round-robin data-memory arbiter with burst limit
// Registered issue stage; read responses routed back to the issuing port in order.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int MEM_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic             owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             grant0, grant1, grant_any, grant_id;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic             issue_id;
  logic [MEM_LAT-1:0] pipe_v, pipe_id;

  // On a tie the owner keeps the port until its burst budget is spent.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (m0_valid && m1_valid) begin
        if ((burst_cnt < MAX_CNT) ? (owner == 1'b0) : (owner == 1'b1))
          grant0 = 1'b1;
        else
          grant1 = 1'b1;
      end else begin
        grant0 = m0_valid;
        grant1 = m1_valid;
      end
    end
  end

  assign grant_any = grant0 | grant1;
  assign grant_id  = grant1;
  assign m0_ready  = grant0;
  assign m1_ready  = grant1;

  always_comb begin
    sel_we    = grant_id ? m1_we    : m0_we;
    sel_addr  = grant_id ? m1_addr  : m0_addr;
    sel_wdata = grant_id ? m1_wdata : m0_wdata;
    sel_be    = grant_id ? m1_be    : m0_be;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      burst_cnt <= '0;
    end else if (grant_any) begin
      if (grant_id == owner) begin
        if (burst_cnt != MAX_CNT)
          burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        owner     <= grant_id;
        burst_cnt <= CNT_W'(1);
      end
    end
  end

  // Issue stage: address/data hold when idle so the RAM sees quiet inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      issue_id  <= 1'b0;
    end else begin
      mem_req <= grant_any;
      mem_we  <= grant_any & sel_we;
      if (grant_any) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_we ? sel_wdata : '0;
        mem_be    <= sel_we ? sel_be : {BE_W{1'b1}};
        issue_id  <= grant_id;
      end
    end
  end

  // Response pipe tracks issued reads; its tail lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v  <= (pipe_v << 1) | MEM_LAT'(mem_req & ~mem_we);
      pipe_id <= (pipe_id << 1) | MEM_LAT'(issue_id);
    end
  end

  assign m0_rvalid = pipe_v[MEM_LAT-1] & ~pipe_id[MEM_LAT-1];
  assign m1_rvalid = pipe_v[MEM_LAT-1] &  pipe_id[MEM_LAT-1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - bench for dmem_port_arbiter with RAM and reference model
module tb_dmem_port_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_we, m1_valid, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        b_m0_valid, b_m1_valid, b_m0_we, b_m1_we;
  logic [31:0] b_m0_addr, b_m1_addr, b_m0_wdata, b_m1_wdata;
  logic [3:0]  b_m0_be, b_m1_be;
  logic        b_m0_ready, b_m1_ready, b_m0_rvalid, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_req, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_we(b_m0_we), .m0_addr(b_m0_addr),
    .m0_wdata(b_m0_wdata), .m0_be(b_m0_be), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_valid(b_m1_valid), .m1_ready(b_m1_ready), .m1_we(b_m1_we), .m1_addr(b_m1_addr),
    .m1_wdata(b_m1_wdata), .m1_be(b_m1_be), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] init_word(input int idx);
    return 32'hC0DE_0000 ^ (32'(idx) * 32'h0001_0103);
  endfunction

  function automatic logic [31:0] tag3(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous RAM, one cycle read latency, byte-writable.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  // Three-cycle tagged memory for the long-latency instance.
  logic [31:0] d3 [3];
  always @(posedge clk) begin
    d3[0] <= tag3(b_mem_addr);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign b_mem_rdata = d3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: run length of the last granted port, shadow memory, response queue.
  typedef struct { int port; logic [31:0] data; int due; } resp_t;
  resp_t       rq[$];
  logic [31:0] shadow [256];
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          acc0 = 1'b0, acc1 = 1'b0;
  int          last_port = 0, run = 0;
  logic        exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  function automatic int model_grant();
    if (rst) return -1;
    if (m0_valid && m1_valid) return (run >= MAX_BURST) ? 1 - last_port : last_port;
    if (m0_valid) return 0;
    if (m1_valid) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    int g;
    bit r0, r1, we;
    logic [31:0] a, d;
    logic [3:0] be;
    cyc++;
    g = model_grant();
    check("m0_ready", 32'(m0_ready), 32'(g == 0));
    check("m1_ready", 32'(m1_ready), 32'(g == 1));
    acc0 = (g == 0);
    acc1 = (g == 1);
    if (armed) begin
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("mem_we", 32'(mem_we), 32'(exp_we));
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_wdata, exp_wdata);
      check("mem_be", 32'(mem_be), 32'(exp_be));
      r0 = rq.size() > 0 && rq[0].due == cyc && rq[0].port == 0;
      r1 = rq.size() > 0 && rq[0].due == cyc && rq[0].port == 1;
      check("m0_rvalid", 32'(m0_rvalid), 32'(r0));
      check("m1_rvalid", 32'(m1_rvalid), 32'(r1));
      if (r0) check("m0_rdata", m0_rdata, rq[0].data);
      if (r1) check("m1_rdata", m1_rdata, rq[0].data);
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    end
    if (rst) begin
      last_port = 0; run = 0; rq.delete();
      exp_req = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
      armed = 1'b1;
    end else begin
      exp_req = (g >= 0);
      exp_we  = 1'b0;
      if (g >= 0) begin
        if (g == last_port) run++;
        else begin last_port = g; run = 1; end
        we = (g == 1) ? m1_we : m0_we;
        a  = (g == 1) ? m1_addr : m0_addr;
        d  = (g == 1) ? m1_wdata : m0_wdata;
        be = (g == 1) ? m1_be : m0_be;
        exp_we = we;
        exp_addr = a;
        if (we) begin
          exp_wdata = d;
          exp_be = be;
          for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
          exp_wdata = 0;
          exp_be = 4'hF;
          rq.push_back('{g, shadow[a[9:2]], cyc + 2});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m1_valid = 0;
    m0_we = 0; m1_we = 0;
    m0_be = 4'hF; m1_be = 4'hF;
  endtask

  task automatic reset_dut();
    tick(); rst = 1; idle_inputs();
    tick(); tick(); rst = 0;
  endtask

  typedef struct { bit v0; bit v1; bit g0; bit g1; } row_t;
  row_t tbl[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle_inputs();
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    b_m0_valid = 0; b_m1_valid = 0; b_m0_we = 0; b_m1_we = 0;
    b_m0_addr = 0; b_m1_addr = 0; b_m0_wdata = 0; b_m1_wdata = 0;
    b_m0_be = 4'hF; b_m1_be = 4'hF;
    for (int i = 0; i < 256; i++) begin
      ram[i] = init_word(i);
      shadow[i] = init_word(i);
    end

    // Arbitration table from reset: burst of four, hand-over, idle hold, single requester.
    tbl = '{'{1,1,1,0}, '{1,1,1,0}, '{1,1,1,0}, '{1,1,1,0},
            '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1},
            '{1,1,1,0}, '{0,0,0,0}, '{0,1,0,1},
            '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,1,0}, '{1,0,1,0}};
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      tick();
      m0_valid = tbl[i].v0; m0_we = 0; m0_addr = 32'h40;
      m1_valid = tbl[i].v1; m1_we = 0; m1_addr = 32'h80;
      #2;
      check($sformatf("tbl%0d_g0", i), 32'(m0_ready), 32'(tbl[i].g0));
      check($sformatf("tbl%0d_g1", i), 32'(m1_ready), 32'(tbl[i].g1));
    end
    tick(); idle_inputs();
    tick(); tick();

    // Single m0 read after reset.
    reset_dut();
    tick(); m0_valid = 1; m0_we = 0; m0_addr = 32'h100; #2;
    check("t1_ready", 32'(m0_ready), 32'd1);
    tick(); m0_valid = 0; #2;
    check("t1_mem_req", 32'(mem_req), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_be", 32'(mem_be), 32'hF);
    tick(); #2;
    check("t1_rvalid", 32'(m0_rvalid), 32'd1);
    check("t1_rdata", m0_rdata, init_word(32'h100 >> 2));
    check("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // m1 partial write, then read back through m0.
    tick(); m1_valid = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hDEADBEEF; m1_be = 4'b0011; #2;
    check("t2_ready", 32'(m1_ready), 32'd1);
    tick(); idle_inputs(); #2;
    check("t2_mem_we", 32'(mem_we), 32'd1);
    check("t2_mem_be", 32'(mem_be), 32'h3);
    check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); #2;
    check("t2_no_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
    tick(); m0_valid = 1; m0_we = 0; m0_addr = 32'h200;
    tick(); idle_inputs();
    tick(); #2;
    check("t2_readback", m0_rdata, {init_word(32'h200 >> 2) >> 16, 16'hBEEF});

    // Alternating single-port reads.
    for (int k = 0; k < 8; k++) begin
      tick();
      m0_valid = (k < 6) && (k % 2 == 0); m0_we = 0; m0_addr = 32'h10;
      m1_valid = (k < 6) && (k % 2 == 1); m1_we = 0; m1_addr = 32'h14;
      #2;
      if (k >= 2) begin
        check($sformatf("t4_rv0_%0d", k), 32'(m0_rvalid), 32'(k % 2 == 0));
        check($sformatf("t4_rv1_%0d", k), 32'(m1_rvalid), 32'(k % 2 == 1));
        if (k % 2 == 0) check("t4_rdata0", m0_rdata, init_word(4));
        else            check("t4_rdata1", m1_rdata, init_word(5));
      end
    end
    tick(); idle_inputs();

    // Reset while a read is in flight; both requesters wait through reset.
    reset_dut();
    tick(); m0_valid = 1; m0_we = 0; m0_addr = 32'h20; #2;
    check("t5_issue", 32'(m0_ready), 32'd1);
    tick(); rst = 1; m0_addr = 32'h40; m1_valid = 1; m1_we = 0; m1_addr = 32'h80; #2;
    check("t5_rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
    tick(); rst = 0; #2;
    check("t5_rvalid_dropped", 32'(m0_rvalid | m1_rvalid), 32'd0);
    check("t5_mem_req", 32'(mem_req), 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    check("t5_mem_be", 32'(mem_be), 32'd0);
    check("t5_tie_m0", 32'({m0_ready, m1_ready}), 32'b10);
    tick(); m0_valid = 0; #2;
    check("t5_m1_next", 32'(m1_ready), 32'd1);
    tick(); m1_valid = 0; #2;
    check("t5_new_rvalid", 32'(m0_rvalid), 32'd1);
    tick(); tick();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      tick();
      rst = ($urandom_range(0, 63) == 0);
      if (!(m0_valid && !acc0)) begin
        m0_valid = ($urandom_range(0, 9) < 7);
        m0_we = $urandom_range(0, 1);
        m0_addr = 32'($urandom_range(0, 15)) * 4;
        m0_wdata = $urandom;
        m0_be = 4'($urandom_range(0, 15));
      end
      if (!(m1_valid && !acc1)) begin
        m1_valid = ($urandom_range(0, 9) < 7);
        m1_we = $urandom_range(0, 1);
        m1_addr = 32'($urandom_range(0, 15)) * 4;
        m1_wdata = $urandom;
        m1_be = 4'($urandom_range(0, 15));
      end
    end
    tick(); rst = 0; idle_inputs();
    tick(); tick(); tick();

    // Long-latency instance: three back-to-back reads return at T+4..T+6.
    reset_dut();
    for (int k = 0; k < 9; k++) begin
      tick();
      b_m0_valid = (k < 3); b_m0_we = 0; b_m0_addr = 32'(k) * 4;
      #2;
      if (k < 3) check($sformatf("t6_ready%0d", k), 32'(b_m0_ready), 32'd1);
      check($sformatf("t6_rvalid%0d", k), 32'(b_m0_rvalid), 32'(k >= 4 && k <= 6));
      check($sformatf("t6_m1rv%0d", k), 32'(b_m1_rvalid), 32'd0);
      if (k >= 4 && k <= 6)
        check($sformatf("t6_rdata%0d", k), b_m0_rdata, tag3(32'(k - 4) * 4));
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
